// File: rtl/logdrop_window_seq_pkg.sv
// Shared types and constants for the logdrop window sequencer.
//   state_e : sequencer state (IDLE / RUN), 1 bit
//   NWIN_W  : width of the completed-window counter
package logdrop_window_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned NWIN_W = 16;

endpackage

// File: rtl/logdrop_window_seq_window.sv
// logdropWindow: combinational log-drop window.
// The sample is attenuated by one binary step (right shift) for every bit of
// the time index's bit-length, so y = x >> bitlen(t), where bitlen(0) = 0.
// The attenuation therefore grows logarithmically across the window.
//   i_t : in-window time index, $clog2(WINLEN) bits
//   i_x : input sample, DATA_W bits
//   o_y : windowed sample, DATA_W bits
// ABSTRACT_MODEL selects a behavioural bit-length search (non-zero) or a
// thermometer-driven shift cascade (zero); both give identical results.
module logdropWindow #(
    parameter int DATA_W         = 8,
    parameter int WINLEN         = 256,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic [$clog2(WINLEN)-1:0] i_t,
    input  logic [DATA_W-1:0]         i_x,
    output logic [DATA_W-1:0]         o_y
);

    localparam int T_W   = $clog2(WINLEN);
    localparam int LEN_W = $clog2(T_W + 1);

    generate
        if (ABSTRACT_MODEL != 0) begin : g_abstract
            logic [LEN_W-1:0] len;

            always_comb begin
                len = '0;
                for (int unsigned i = 0; i < T_W; i++) begin
                    if (i_t[i]) begin
                        len = LEN_W'(i + 1);
                    end
                end
                o_y = i_x >> len;
            end
        end else begin : g_struct
            // th[i] is set when any bit at or above i is set; its popcount is
            // the bit-length, so one 1-bit shift per set stage gives x >> len.
            logic [T_W-1:0]    th;
            logic [DATA_W-1:0] stage [T_W+1];

            always_comb begin
                th[T_W-1] = i_t[T_W-1];
                for (int i = T_W - 2; i >= 0; i--) begin
                    th[i] = th[i+1] | i_t[i];
                end
            end

            assign stage[0] = i_x;

            for (genvar g = 0; g < T_W; g++) begin : g_stage
                assign stage[g+1] = th[g] ? (stage[g] >> 1) : stage[g];
            end

            assign o_y = stage[T_W];
        end
    endgenerate

endmodule

// File: rtl/logdrop_window_seq.sv
// logdrop_window_seq: sequencer around the logdropWindow datapath.
// Accepts a valid/ready sample stream, tags each accepted sample with its
// in-window time index t, windows it, and presents the result through a
// registered valid/ready output with first/last window markers.
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_start / i_stop       : begin a window (IDLE) / abort a window (RUN)
//   i_continuous           : at window end, 1 = start next window, 0 = IDLE
//   i_x, i_x_valid, o_x_ready : input sample stream
//   o_y, o_t, o_first, o_last, o_y_valid, i_y_ready : output stream
//   o_busy                 : sequencer is in RUN
//   o_nWindows             : completed windows, wraps at 2**16
module logdrop_window_seq
    import logdrop_window_seq_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int LOG2_WINLEN    = 8,
    parameter int ABSTRACT_MODEL = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_continuous,
    input  logic [DATA_W-1:0]      i_x,
    input  logic                   i_x_valid,
    output logic                   o_x_ready,
    output logic [DATA_W-1:0]      o_y,
    output logic [LOG2_WINLEN-1:0] o_t,
    output logic                   o_first,
    output logic                   o_last,
    output logic                   o_y_valid,
    input  logic                   i_y_ready,
    output logic                   o_busy,
    output logic [NWIN_W-1:0]      o_nWindows
);

    localparam int WINLEN = 2 ** LOG2_WINLEN;

    state_e                  state_q, state_d;
    logic [LOG2_WINLEN-1:0]  t_q, t_d;
    logic [NWIN_W-1:0]       nwin_q, nwin_d;

    logic [DATA_W-1:0]       y_q;
    logic [LOG2_WINLEN-1:0]  ot_q;
    logic                    first_q, last_q, yv_q;

    logic                    x_ready;
    logic                    accept;
    logic                    t_is_last;
    logic [DATA_W-1:0]       win_y;

    logdropWindow #(
        .DATA_W         (DATA_W),
        .WINLEN         (WINLEN),
        .ABSTRACT_MODEL (ABSTRACT_MODEL)
    ) u_window (
        .i_t (t_q),
        .i_x (i_x),
        .o_y (win_y)
    );

    assign t_is_last = (t_q == '1);

    // State register (also holds the t counter and window count).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            nwin_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            nwin_q  <= nwin_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        nwin_d  = nwin_q;
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = RUN;
                    t_d     = '0;
                end
            end
            RUN: begin
                if (i_stop) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else if (accept) begin
                    t_d = t_q + 1'b1;
                    if (t_is_last) begin
                        nwin_d = nwin_q + 1'b1;
                        if (!i_continuous) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Output logic; i_stop gates ready so an abort never accepts a sample.
    always_comb begin
        o_busy  = (state_q == RUN);
        x_ready = (state_q == RUN) && !i_stop && (!yv_q || i_y_ready);
        accept  = i_x_valid && x_ready;
    end

    // Output register: loads on accept, otherwise drains when downstream is ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            y_q     <= '0;
            ot_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            yv_q    <= 1'b0;
        end else if (accept) begin
            y_q     <= win_y;
            ot_q    <= t_q;
            first_q <= (t_q == '0);
            last_q  <= t_is_last;
            yv_q    <= 1'b1;
        end else if (i_y_ready) begin
            yv_q    <= 1'b0;
        end
    end

    assign o_x_ready  = x_ready;
    assign o_y        = y_q;
    assign o_t        = ot_q;
    assign o_first    = first_q;
    assign o_last     = last_q;
    assign o_y_valid  = yv_q;
    assign o_nWindows = nwin_q;

endmodule

// File: tb/tb_logdrop_window_seq.sv
module tb_logdrop_window_seq;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int WL = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, cont;
    logic [DW-1:0] x;
    logic          xv;
    logic          x_ready;
    logic [DW-1:0] y;
    logic [LW-1:0] t_o;
    logic          first, last, yv;
    logic          yready;
    logic          busy;
    logic [15:0]   nwin;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logdrop_window_seq #(
        .DATA_W         (DW),
        .LOG2_WINLEN    (LW),
        .ABSTRACT_MODEL (0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_continuous (cont),
        .i_x          (x),
        .i_x_valid    (xv),
        .o_x_ready    (x_ready),
        .o_y          (y),
        .o_t          (t_o),
        .o_first      (first),
        .o_last       (last),
        .o_y_valid    (yv),
        .i_y_ready    (yready),
        .o_busy       (busy),
        .o_nWindows   (nwin)
    );

    // ---------------- reference model ----------------
    function automatic int bitlen(int v);
        int n = 0;
        while (v > 0) begin
            v = v / 2;
            n++;
        end
        return n;
    endfunction

    function automatic int win(int t, int xv_in);
        int n = bitlen(t);
        if (n >= DW) return 0;
        return xv_in / (2 ** n);
    endfunction

    bit m_run;
    int m_t;
    bit m_yv;
    int m_y;
    int m_ot;
    bit m_first, m_last;
    int m_nwin;
    bit m_rdy, m_acc;

    always_comb begin
        m_rdy = m_run && !stop && (!m_yv || yready);
        m_acc = xv && m_rdy;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 0; m_t <= 0; m_yv <= 0; m_y <= 0; m_ot <= 0;
            m_first <= 0; m_last <= 0; m_nwin <= 0;
        end else begin
            if (!m_run) begin
                if (start && !stop) begin
                    m_run <= 1;
                    m_t   <= 0;
                end
            end else if (stop) begin
                m_run <= 0;
                m_t   <= 0;
            end else if (m_acc) begin
                m_t <= (m_t + 1) % WL;
                if (m_t == WL - 1) begin
                    m_nwin <= (m_nwin + 1) % 65536;
                    if (!cont) m_run <= 0;
                end
            end
            if (m_acc) begin
                m_yv    <= 1;
                m_y     <= win(m_t, int'(x));
                m_ot    <= m_t;
                m_first <= (m_t == 0);
                m_last  <= (m_t == WL - 1);
            end else if (yready) begin
                m_yv <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("x_ready", int'(x_ready), int'(m_rdy));
        chk("y_valid", int'(yv), int'(m_yv));
        chk("busy", int'(busy), int'(m_run));
        chk("nWindows", int'(nwin), m_nwin);
        chk("y", int'(y), m_y);
        chk("t", int'(t_o), m_ot);
        chk("first", int'(first), int'(m_first));
        chk("last", int'(last), int'(m_last));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int nacc, nout;
    logic [3:0] pat;
    bit acc, hs;

    initial begin
        rst = 1; start = 0; stop = 0; cont = 0; x = '0; xv = 0; yready = 1;
        pat = 4'b1001;

        // pin the model's window function with hand-computed values
        chk("win_t0", win(0, 200), 200);
        chk("win_t1", win(1, 200), 100);
        chk("win_t3", win(3, 200), 50);
        chk("win_t64", win(64, 200), 1);
        chk("win_t128", win(128, 200), 0);

        cycle(); cycle();
        chk("rst_nwin", int'(nwin), 0);
        chk("rst_yv", int'(yv), 0);
        rst = 0;
        cycle();
        xv = 1;
        cycle();
        chk("idle_ready", int'(x_ready), 0);
        xv = 0;

        // single window at full rate, x = t
        start = 1; cycle(); start = 0;
        xv = 1; yready = 1; cont = 0;
        for (int k = 0; k < WL; k++) begin
            x = DW'(k);
            cycle();
            if (k == 0) begin
                chk("w1_first", int'(first), 1);
                chk("w1_t0", int'(t_o), 0);
            end
        end
        chk("w1_t255", int'(t_o), 255);
        chk("w1_last", int'(last), 1);
        chk("w1_y", int'(y), 0);
        xv = 0;
        cycle();
        chk("w1_nwin", int'(nwin), 1);
        chk("w1_busy", int'(busy), 0);
        chk("w1_ready", int'(x_ready), 0);

        // backpressure 1,0,0,1
        start = 1; cycle(); start = 0;
        xv = 1; x = DW'($urandom); nacc = 0; nout = 0;
        for (int n = 0; n < 40; n++) begin
            yready = pat[n % 4];
            @(negedge clk);
            acc = x_ready && xv;
            hs  = yv && yready;
            cycle();
            if (acc) begin
                nacc++;
                x = DW'($urandom);
            end
            if (hs) nout++;
        end
        xv = 0; stop = 1; yready = 1;
        @(negedge clk);
        if (yv) nout++;
        cycle();
        stop = 0;
        cycle();
        chk("bp_no_loss", nout, nacc);
        chk("bp_nwin", int'(nwin), 1);

        // continuous: three back-to-back windows
        cont = 1; start = 1; cycle(); start = 0;
        xv = 1; yready = 1; nacc = 0;
        for (int n = 0; n < 3 * WL; n++) begin
            x = DW'($urandom);
            cont = (n == 3 * WL - 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (x_ready) nacc++;
            cycle();
            if (n == WL) begin
                chk("cont_wrap_t", int'(t_o), 0);
                chk("cont_wrap_first", int'(first), 1);
            end
        end
        xv = 0; cont = 0;
        cycle();
        chk("cont_accepts", nacc, 3 * WL);
        chk("cont_nwin", int'(nwin), 4);
        chk("cont_busy", int'(busy), 0);

        // abort at t=100 with the t=99 output still pending
        start = 1; cycle(); start = 0;
        xv = 1; yready = 1; x = 8'd200;
        for (int n = 0; n < 100; n++) cycle();
        stop = 1; yready = 0;
        @(negedge clk);
        chk("abort_ready", int'(x_ready), 0);
        cycle();
        stop = 0; xv = 0;
        chk("abort_pending_v", int'(yv), 1);
        chk("abort_pending_t", int'(t_o), 99);
        chk("abort_pending_y", int'(y), 1);
        chk("abort_busy", int'(busy), 0);
        yready = 1;
        cycle();
        chk("abort_drained", int'(yv), 0);
        chk("abort_nolast", int'(last), 0);
        chk("abort_nwin", int'(nwin), 4);
        start = 1; cycle(); start = 0;
        xv = 1; x = 8'd200;
        cycle();
        chk("restart_t", int'(t_o), 0);
        chk("restart_y", int'(y), 200);
        xv = 0; stop = 1; cycle(); stop = 0;

        // start with stop in IDLE; start in RUN ignored
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        chk("startstop_idle", int'(busy), 0);
        start = 1; cycle(); start = 0;
        xv = 1; x = 8'd100;
        for (int n = 0; n < 10; n++) cycle();
        start = 1; cycle(); start = 0;
        chk("run_start_t10", int'(t_o), 10);
        cycle();
        chk("run_start_t11", int'(t_o), 11);

        // reset mid-window with t=37 and output valid
        stop = 1; cycle(); stop = 0;
        start = 1; cycle(); start = 0;
        for (int n = 0; n < 37; n++) cycle();
        chk("pre_rst_t", int'(t_o), 36);
        chk("pre_rst_v", int'(yv), 1);
        #2 rst = 1;
        #1;
        chk("arst_y", int'(y), 0);
        chk("arst_t", int'(t_o), 0);
        chk("arst_v", int'(yv), 0);
        chk("arst_first", int'(first), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(x_ready), 0);
        chk("arst_nwin", int'(nwin), 0);
        cycle();
        rst = 0;
        cycle(); cycle();
        chk("post_rst_ready", int'(x_ready), 0);
        xv = 0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
